// File: rtl/main_memory_responder.sv
// main_memory_responder: word RAM behind the L2 memory port with a fixed
// access latency, a one-deep pending slot and a post-reset clear sweep.
// Optional completion counters are enabled by defining MEM_STATS_EN.
module main_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_valid,
    output logic [31:0] read_count,
    output logic [31:0] write_count
);

    localparam int            AW         = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH_WORDS - 1);
    localparam logic [3:0]    LAT_RELOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] init_ptr_q, init_ptr_d;
    logic [3:0]    lat_cnt_q, lat_cnt_d;

    // Active slot: the request currently counting down its latency.
    logic          act_write_q, act_write_d;
    logic [AW-1:0] act_idx_q, act_idx_d;
    logic [31:0]   act_data_q, act_data_d;

    // Pending slot: one request parked while the active one is in flight.
    logic          pend_valid_q, pend_valid_d;
    logic          pend_write_q, pend_write_d;
    logic [AW-1:0] pend_idx_q, pend_idx_d;
    logic [31:0]   pend_data_q, pend_data_d;

    logic          mem_ready_q, mem_ready_d;
    logic          mem_valid_q, mem_valid_d;
    logic [31:0]   mem_read_data_q, mem_read_data_d;

    // Storage array and its single write port.
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    logic          accept;
    logic          lat_done;
    logic          complete;
    logic [AW-1:0] req_idx;
    logic          unused_addr_bits;

    assign accept   = mem_req & mem_ready_q;
    assign lat_done = (lat_cnt_q == 4'd0);
    assign complete = (state_q == ST_BUSY) & lat_done;
    assign req_idx  = mem_addr[AW+1:2];

    // Byte offset and bits above the array size alias onto the same word.
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sweep, then idle/busy depending on outstanding work.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (lat_done && !pend_valid_q && !accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Outputs and datapath: sweep writes, slot capture, completion.
    always_comb begin
        init_ptr_d      = init_ptr_q;
        lat_cnt_d       = lat_cnt_q;
        act_write_d     = act_write_q;
        act_idx_d       = act_idx_q;
        act_data_d      = act_data_q;
        pend_valid_d    = pend_valid_q;
        pend_write_d    = pend_write_q;
        pend_idx_d      = pend_idx_q;
        pend_data_d     = pend_data_q;
        mem_ready_d     = mem_ready_q;
        mem_valid_d     = 1'b0;
        mem_read_data_d = mem_read_data_q;
        mem_we          = 1'b0;
        mem_widx        = act_idx_q;
        mem_wdata       = act_data_q;

        unique case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_widx   = init_ptr_q;
                mem_wdata  = 32'd0;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_IDX) begin
                    mem_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                mem_ready_d = 1'b1;
                if (accept) begin
                    act_write_d = mem_write;
                    act_idx_d   = req_idx;
                    act_data_d  = mem_write_data;
                    lat_cnt_d   = LAT_RELOAD;
                end
            end
            ST_BUSY: begin
                if (!lat_done) begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                    if (accept) begin
                        pend_valid_d = 1'b1;
                        pend_write_d = mem_write;
                        pend_idx_d   = req_idx;
                        pend_data_d  = mem_write_data;
                    end
                end else begin
                    mem_valid_d = 1'b1;
                    if (act_write_q) begin
                        mem_we    = 1'b1;
                        mem_widx  = act_idx_q;
                        mem_wdata = act_data_q;
                    end else begin
                        mem_read_data_d = mem_q[act_idx_q];
                    end
                    if (pend_valid_q) begin
                        act_write_d  = pend_write_q;
                        act_idx_d    = pend_idx_q;
                        act_data_d   = pend_data_q;
                        lat_cnt_d    = LAT_RELOAD;
                        pend_valid_d = accept;
                        if (accept) begin
                            pend_write_d = mem_write;
                            pend_idx_d   = req_idx;
                            pend_data_d  = mem_write_data;
                        end
                    end else if (accept) begin
                        act_write_d = mem_write;
                        act_idx_d   = req_idx;
                        act_data_d  = mem_write_data;
                        lat_cnt_d   = LAT_RELOAD;
                    end
                end
                mem_ready_d = ~pend_valid_d;
            end
            default: begin
                mem_ready_d = 1'b0;
            end
        endcase
    end

    // Control and slot registers; reset discards any in-flight work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_ptr_q      <= '0;
            lat_cnt_q       <= 4'd0;
            act_write_q     <= 1'b0;
            act_idx_q       <= '0;
            act_data_q      <= 32'd0;
            pend_valid_q    <= 1'b0;
            pend_write_q    <= 1'b0;
            pend_idx_q      <= '0;
            pend_data_q     <= 32'd0;
            mem_ready_q     <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_read_data_q <= 32'd0;
        end else begin
            init_ptr_q      <= init_ptr_d;
            lat_cnt_q       <= lat_cnt_d;
            act_write_q     <= act_write_d;
            act_idx_q       <= act_idx_d;
            act_data_q      <= act_data_d;
            pend_valid_q    <= pend_valid_d;
            pend_write_q    <= pend_write_d;
            pend_idx_q      <= pend_idx_d;
            pend_data_q     <= pend_data_d;
            mem_ready_q     <= mem_ready_d;
            mem_valid_q     <= mem_valid_d;
            mem_read_data_q <= mem_read_data_d;
        end
    end

    // Array write port; contents are cleared by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign mem_ready     = mem_ready_q;
    assign mem_valid     = mem_valid_q;
    assign mem_read_data = mem_read_data_q;

`ifdef MEM_STATS_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;

    // Count completions by kind; wraps naturally at 2^32.
    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (complete) begin
            if (act_write_q) begin
                write_count_d = write_count_q + 32'd1;
            end else begin
                read_count_d = read_count_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_count_q  <= 32'd0;
            write_count_q <= 32'd0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`else
    logic unused_complete;

    assign unused_complete = complete;
    assign read_count      = 32'd0;
    assign write_count     = 32'd0;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed table, corner sequences and random
// traffic against a transaction-level reference model.
module tb_main_memory_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_write_data = 32'd0;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] read_count;
    logic [31:0] write_count;

    always #5 clk = ~clk;

    main_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_req(mem_req),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .mem_ready(mem_ready),
        .mem_valid(mem_valid),
        .read_count(read_count),
        .write_count(write_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding requests carry their completion time.
    typedef struct {
        bit          wr;
        int unsigned idx;
        logic [31:0] data;
        longint      done;
    } txn_t;

    txn_t        q[$];
    logic [31:0] m_mem [DEPTH];
    logic        m_ready = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] m_rc = 32'd0;
    logic [31:0] m_wc = 32'd0;
    int          init_left = DEPTH;
    longint      now = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        txn_t   t;
        bit     acc;
        longint base;
        if (reset) begin
            q.delete();
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_rdata = 32'd0;
            m_rc = 32'd0;
            m_wc = 32'd0;
            init_left = DEPTH;
            foreach (m_mem[i]) m_mem[i] = 32'd0;
            return;
        end
        now++;
        m_valid = 1'b0;
        if (init_left > 0) begin
            init_left--;
            m_ready = (init_left == 0);
            return;
        end
        acc = mem_req && m_ready;
        if (q.size() > 0 && q[0].done == now) begin
            t = q.pop_front();
            m_valid = 1'b1;
            if (t.wr) begin
                m_mem[t.idx] = t.data;
                m_wc++;
            end else begin
                m_rdata = m_mem[t.idx];
                m_rc++;
            end
        end
        if (acc) begin
            base = (q.size() > 0) ? q[q.size()-1].done : now;
            t.wr = mem_write;
            t.idx = (mem_addr >> 2) % DEPTH;
            t.data = mem_write_data;
            t.done = base + LAT;
            q.push_back(t);
        end
        m_ready = (q.size() < 2);
    endtask

    task automatic tick();
        logic [31:0] erc;
        logic [31:0] ewc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
`ifdef MEM_STATS_EN
        erc = m_rc;
        ewc = m_wc;
`else
        erc = 32'd0;
        ewc = 32'd0;
`endif
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, m_ready});
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_valid});
        chk("mem_read_data", mem_read_data, m_rdata);
        chk("read_count", read_count, erc);
        chk("write_count", write_count, ewc);
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!mem_ready && k < 2000) begin
            tick();
            k++;
        end
        chk({name, "_ready"}, {31'd0, mem_ready}, 32'd1);
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp,
                          input string name);
        int lat;
        wait_ready(name);
        mem_req = 1'b1;
        mem_write = wr;
        mem_addr = addr;
        mem_write_data = data;
        tick();
        mem_req = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!mem_valid && lat < 20);
        chk({name, "_lat"}, lat, LAT);
        chk({name, "_rdata"}, mem_read_data, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nr;
        int nw;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'hDEADBEEF,  32'h0000_0000};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEADBEEF};
        vecs[3] = '{1'b1, 32'h0000_1004, 32'h0000_1234, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 32'h0000_0006, 32'h0,         32'h0000_1234};
        vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0000};
        vecs[6] = '{1'b1, 32'h0000_0FFC, 32'hA5A5A5A5,  32'h0000_0000};
        vecs[7] = '{1'b0, 32'h0001_3FFC, 32'h0,         32'hA5A5A5A5};

        // Reset and sweep length.
        tick();
        tick();
        reset = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_ready && n < 2000);
        chk("init_cycles", n, DEPTH);

        // Directed table.
        nr = 0;
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, $sformatf("vec%0d", i));
            if (vecs[i].wr) nw++;
            else nr++;
        end
`ifdef MEM_STATS_EN
        chk("t6_reads", read_count, nr);
        chk("t6_writes", write_count, nw);
`else
        chk("t6_reads", read_count, 32'd0);
        chk("t6_writes", write_count, 32'd0);
`endif

        // Back-to-back write/read, third pulse dropped.
        wait_ready("t3");
        mem_req = 1'b1;
        mem_write = 1'b1;
        mem_addr = 32'h80;
        mem_write_data = 32'h55AA1234;
        tick();
        mem_write = 1'b0;
        tick();
        chk("t3_ready_low", {31'd0, mem_ready}, 32'd0);
        mem_write = 1'b1;
        mem_write_data = 32'hFFFFFFFF;
        tick();
        mem_req = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_valid && n < 20);
        chk("t3_wr_done", n, 2);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_valid && n < 20);
        chk("t3_rd_gap", n, LAT);
        chk("t3_rd_data", mem_read_data, 32'h55AA1234);
        do_txn(1'b0, 32'h80, 32'h0, 32'h55AA1234, "t3_drop");

        // Reset two edges into a busy read.
        do_txn(1'b1, 32'h200, 32'h77, 32'h55AA1234, "t5_wr");
        mem_req = 1'b1;
        mem_write = 1'b0;
        mem_addr = 32'h200;
        tick();
        mem_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t5_async_ready", {31'd0, mem_ready}, 32'd0);
        chk("t5_async_valid", {31'd0, mem_valid}, 32'd0);
        chk("t5_async_rdata", mem_read_data, 32'd0);
        chk("t5_async_rc", read_count, 32'd0);
        chk("t5_async_wc", write_count, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        do_txn(1'b0, 32'h200, 32'h0, 32'h0, "t5_cleared");

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            mem_req = ($urandom_range(0, 99) < 60);
            mem_write = 1'($urandom_range(0, 1));
            mem_addr = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3)
                     | ($urandom_range(0, 3) << 12);
            mem_write_data = $urandom;
            if (i == 200) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        mem_req = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
